// File: rtl/cosim_mmio_arbiter.sv
// Serialises MMIO store events from N_CH device taps into the single cosim report port.
// Define COSIM_MMIO_RR_ARB_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module cosim_mmio_arbiter #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 64,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_store,
    input  logic [N_CH*ADDR_W-1:0]   in_addr,
    input  logic [N_CH*DATA_W-1:0]   in_val,
    input  logic [N_CH*LEN_W-1:0]    in_len,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     out_store,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_val,
    output logic [LEN_W-1:0]         out_len,
    output logic [$clog2(N_CH)-1:0]  out_src,
    input  logic                     ovf_clr,
    output logic [N_CH-1:0]          ovf_flag,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int SRC_W = $clog2(N_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = SRC_W + ADDR_W + DATA_W + LEN_W;

    logic [N_CH-1:0]   slot_full_q, slot_full_d;
    logic [ADDR_W-1:0] slot_addr_q [N_CH];
    logic [DATA_W-1:0] slot_val_q  [N_CH];
    logic [LEN_W-1:0]  slot_len_q  [N_CH];
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]   ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [N_CH-1:0]   load, ovf_hit;
    logic [SRC_W-1:0]  grant_idx, cand_idx;
    logic              grant_vld, push, pop, full;
    logic [3:0]        drop_n;
    logic [CNT_W:0]    drop_sum;
    logic [ENT_W-1:0]  head;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_store = pop;
    assign head      = mem_q[rd_ptr_q];
    assign {out_src, out_addr, out_val, out_len} = out_valid ? head : '0;
    assign ovf_flag  = ovf_flag_q;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        grant_vld   = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        // Scan from the far end so the candidate nearest the pointer wins last.
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand_idx = SRC_W'((int'(rr_ptr_q) + k) % N_CH);
            if (slot_full_q[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        push = grant_vld && (!full || pop);

        slot_full_d = slot_full_q;
        load        = '0;
        ovf_hit     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_store[i]) begin
                if (!slot_full_q[i] || (push && grant_idx == SRC_W'(i))) begin
                    load[i]        = 1'b1;
                    slot_full_d[i] = 1'b1;
                end else begin
                    ovf_hit[i] = 1'b1;
                end
            end else if (push && grant_idx == SRC_W'(i)) begin
                slot_full_d[i] = 1'b0;
            end
        end

        drop_n = '0;
        for (int i = 0; i < N_CH; i++) begin
            drop_n = drop_n + {3'b000, ovf_hit[i]};
        end
        drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_n);
        if (ovf_clr) begin
            ovf_flag_d = '0;
            drop_cnt_d = '0;
        end else begin
            ovf_flag_d = ovf_flag_q | ovf_hit;
            drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

`ifdef COSIM_MMIO_RR_ARB_EN
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (grant_idx == SRC_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
`else
        rr_ptr_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            ovf_flag_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            ovf_flag_q  <= ovf_flag_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by slot_full_q and count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (load[i]) begin
                slot_addr_q[i] <= in_addr[i*ADDR_W +: ADDR_W];
                slot_val_q[i]  <= in_val[i*DATA_W +: DATA_W];
                slot_len_q[i]  <= in_len[i*LEN_W +: LEN_W];
            end
        end
        if (push) begin
            mem_q[wr_ptr_q] <= {grant_idx, slot_addr_q[grant_idx],
                                slot_val_q[grant_idx], slot_len_q[grant_idx]};
        end
    end
endmodule
